// File: rtl/nibble_word_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Package : nibble_word_assembler_pkg
// Purpose : Shared defaults, FSM state type and partial-word padding helper
//           for the nibble word assembler.
// Rev     : 1.0  initial release
// ============================================================================
package nibble_word_assembler_pkg;

  localparam int NIB_W_DEF  = 4;
  localparam int WORD_W_DEF = 32;
  // Working width of the padding helper; WORD_W must not exceed this.
  localparam int PAD_MAX_W  = 256;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    LAST    = 1'b1
  } asm_state_t;

  // Align a partially filled accumulator holding `count` nibbles.
  // MSB-first accumulators fill from the bottom, so the nibbles are moved up
  // to the top of the word; LSB-first accumulators fill from the top, so the
  // nibbles are moved down to bit 0. Vacated nibbles become zero.
  function automatic logic [PAD_MAX_W-1:0] pad_partial(
    input logic [PAD_MAX_W-1:0] acc,
    input int                   count,
    input int                   nib_w,
    input int                   word_w,
    input bit                   msb_first
  );
    int shift;
    shift = (word_w / nib_w - count) * nib_w;
    if (msb_first) return acc << shift;
    else           return acc >> shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_word_assembler_acc.sv
`default_nettype none
// ============================================================================
// Module  : nibble_word_assembler_acc
// Purpose : Nibble accumulator shift register with occupancy count.
// Ports   : clk, rst      - clock, asynchronous active-high reset
//           accept        - shift nib_in into the accumulator
//           clear         - empty the accumulator (wins over accept)
//           nib_in        - incoming nibble
//           acc           - current accumulator contents
//           acc_shift     - accumulator with nib_in shifted in (combinational)
//           count         - nibbles currently held
// Rev     : 1.0  initial release
// ============================================================================
module nibble_word_assembler_acc #(
  parameter int NIB_W     = 4,
  parameter int WORD_W    = 32,
  parameter int MSB_FIRST = 1,
  parameter int CW        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              clear,
  input  logic [NIB_W-1:0]  nib_in,
  output logic [WORD_W-1:0] acc,
  output logic [WORD_W-1:0] acc_shift,
  output logic [CW-1:0]     count
);

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign acc_shift = {acc[WORD_W-NIB_W-1:0], nib_in};
    end else begin : g_lsb_first
      assign acc_shift = {nib_in, acc[WORD_W-1:NIB_W]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
    end else if (clear) begin
      // Completion and flush both consume any same-cycle nibble via acc_shift
      // in the parent, so clearing here never loses data.
      acc   <= '0;
      count <= '0;
    end else if (accept) begin
      acc   <= acc_shift;
      count <= count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/nibble_word_assembler.sv
`default_nettype none
// ============================================================================
// Module  : nibble_word_assembler
// Purpose : Packs a stream of nibbles into WORD_W-bit words held in a single
//           valid/ready output slot; flush emits a zero-padded partial word.
// Ports   : CLK, RST       - clock, asynchronous active-high reset
//           nib_in/valid/ready - nibble input handshake
//           flush          - emit partial word (zero-padded)
//           word_out/valid/ready - output slot handshake
//           word_partial   - slot word came from a flush
//           nib_count      - nibbles held in the accumulator
// Rev     : 1.0  initial release
// ============================================================================
module nibble_word_assembler
  import nibble_word_assembler_pkg::*;
#(
  parameter int NIB_W     = NIB_W_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NIB_W-1:0]                 nib_in,
  input  logic                             nib_valid,
  output logic                             nib_ready,
  input  logic                             flush,
  output logic [WORD_W-1:0]                word_out,
  output logic                             word_valid,
  input  logic                             word_ready,
  output logic                             word_partial,
  output logic [$clog2(WORD_W/NIB_W):0]    nib_count
);

  localparam int N  = WORD_W / NIB_W;
  localparam int CW = $clog2(N) + 1;

  asm_state_t        state;
  logic              flush_pend;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_shift;
  logic [WORD_W-1:0] eff_acc;
  logic [WORD_W-1:0] pad_word;
  logic [CW-1:0]     count;
  logic [CW-1:0]     eff_cnt;
  logic              slot_free;
  logic              accept;
  logic              complete;
  logic              flush_active;
  logic              load_partial;
  logic              clear;

  assign slot_free = ~word_valid | word_ready;
  // In LAST the completing nibble needs the slot, hence the word_ready path.
  assign nib_ready = ~flush_pend & ((state == COLLECT) | slot_free);
  assign accept    = nib_valid & nib_ready;
  assign complete  = accept & (state == LAST);

  // State as it stands after absorbing any same-cycle nibble; flush acts on it.
  assign eff_acc = accept ? acc_shift : acc;
  assign eff_cnt = count + CW'(accept);

  assign flush_active = flush_pend | (flush & ((count != '0) | accept));
  assign load_partial = ~complete & flush_active & slot_free;
  assign clear        = complete | load_partial;

  assign pad_word = WORD_W'(pad_partial(PAD_MAX_W'(eff_acc), int'(eff_cnt),
                                        NIB_W, WORD_W, MSB_FIRST != 0));

  assign nib_count = count;

  nibble_word_assembler_acc #(
    .NIB_W     (NIB_W),
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST),
    .CW        (CW)
  ) u_acc (
    .clk       (CLK),
    .rst       (RST),
    .accept    (accept),
    .clear     (clear),
    .nib_in    (nib_in),
    .acc       (acc),
    .acc_shift (acc_shift),
    .count     (count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= COLLECT;
      flush_pend   <= 1'b0;
      word_out     <= '0;
      word_valid   <= 1'b0;
      word_partial <= 1'b0;
    end else begin
      if (complete) begin
        // A flush arriving with the completing nibble is satisfied by this word.
        word_out     <= acc_shift;
        word_valid   <= 1'b1;
        word_partial <= 1'b0;
        flush_pend   <= 1'b0;
      end else if (load_partial) begin
        word_out     <= pad_word;
        word_valid   <= 1'b1;
        word_partial <= 1'b1;
        flush_pend   <= 1'b0;
      end else begin
        // Reaching here with flush_active means the slot is busy.
        if (flush_active) flush_pend <= 1'b1;
        if (word_valid & word_ready) word_valid <= 1'b0;
      end

      if (clear) begin
        state <= COLLECT;
      end else if (accept && (eff_cnt == CW'(N - 1))) begin
        state <= LAST;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_word_assembler.sv
`default_nettype none
// ============================================================================
// Module  : tb_nibble_word_assembler
// Purpose : Directed self-checking bench; an MSB-first and an LSB-first
//           instance share the same input stimulus.
// Rev     : 1.0  initial release
// ============================================================================
module tb_nibble_word_assembler;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  nib_in;
  logic        nib_valid;
  logic        flush;
  logic        word_ready;

  logic        a_nib_ready, b_nib_ready;
  logic [31:0] a_word, b_word;
  logic        a_valid, b_valid;
  logic        a_partial, b_partial;
  logic [3:0]  a_count, b_count;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  nibble_word_assembler #(.NIB_W(4), .WORD_W(32), .MSB_FIRST(1)) dut_msb (
    .CLK          (CLK),
    .RST          (RST),
    .nib_in       (nib_in),
    .nib_valid    (nib_valid),
    .nib_ready    (a_nib_ready),
    .flush        (flush),
    .word_out     (a_word),
    .word_valid   (a_valid),
    .word_ready   (word_ready),
    .word_partial (a_partial),
    .nib_count    (a_count)
  );

  nibble_word_assembler #(.NIB_W(4), .WORD_W(32), .MSB_FIRST(0)) dut_lsb (
    .CLK          (CLK),
    .RST          (RST),
    .nib_in       (nib_in),
    .nib_valid    (nib_valid),
    .nib_ready    (b_nib_ready),
    .flush        (flush),
    .word_out     (b_word),
    .word_valid   (b_valid),
    .word_ready   (word_ready),
    .word_partial (b_partial),
    .nib_count    (b_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents one nibble for one edge; callers ensure the assembler is ready.
  task automatic push(input logic [3:0] n);
    nib_valid = 1'b1;
    nib_in    = n;
    tick();
    nib_valid = 1'b0;
    nib_in    = 4'h0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    RST        = 1'b1;
    nib_in     = 4'h0;
    nib_valid  = 1'b0;
    flush      = 1'b0;
    word_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid",   {31'd0, a_valid},   32'd0);
    chk("rst_count",   {28'd0, a_count},   32'd0);
    chk("rst_word",    a_word,             32'd0);
    chk("rst_partial", {31'd0, a_partial}, 32'd0);
    RST = 1'b0;
    tick();
    chk("idle_ready",  {31'd0, a_nib_ready}, 32'd1);

    // Basic word, back-to-back nibbles 1..8
    for (int i = 1; i <= 8; i++) push(4'(i));
    chk("basic_word",    a_word,             32'h12345678);
    chk("basic_valid",   {31'd0, a_valid},   32'd1);
    chk("basic_partial", {31'd0, a_partial}, 32'd0);
    chk("basic_count",   {28'd0, a_count},   32'd0);
    chk("lsb_word",      b_word,             32'h87654321);
    tick();
    chk("basic_drain",   {31'd0, a_valid},   32'd0);

    // Backpressure: slot full with word_ready low
    word_ready = 1'b0;
    push(4'h9); push(4'hA); push(4'hB); push(4'hC);
    push(4'hD); push(4'hE); push(4'hF); push(4'h0);
    chk("bp_fill",   a_word, 32'h9ABCDEF0);
    chk("bp_fill_b", b_word, 32'h0FEDCBA9);
    for (int i = 1; i <= 7; i++) push(4'(i));
    chk("bp_count7", {28'd0, a_count}, 32'd7);
    nib_valid = 1'b1;
    nib_in    = 4'h8;
    #1;
    chk("bp_ready_low", {31'd0, a_nib_ready}, 32'd0);
    tick();
    tick();
    chk("bp_hold_word",  a_word,            32'h9ABCDEF0);
    chk("bp_hold_count", {28'd0, a_count},  32'd7);
    word_ready = 1'b1;
    #1;
    chk("bp_ready_high", {31'd0, a_nib_ready}, 32'd1);
    tick();
    nib_valid = 1'b0;
    chk("bp_new_word",  a_word,           32'h12345678);
    chk("bp_new_valid", {31'd0, a_valid}, 32'd1);
    chk("bp_new_count", {28'd0, a_count}, 32'd0);
    tick();
    chk("bp_drain", {31'd0, a_valid}, 32'd0);

    // Flush partial
    push(4'hA); push(4'hB); push(4'hC);
    pulse_flush();
    chk("fl_word",    a_word,             32'hABC00000);
    chk("fl_partial", {31'd0, a_partial}, 32'd1);
    chk("fl_valid",   {31'd0, a_valid},   32'd1);
    chk("fl_count",   {28'd0, a_count},   32'd0);
    chk("fl_word_b",  b_word,             32'h00000CBA);
    tick();
    pulse_flush();
    chk("fl_empty", {31'd0, a_valid}, 32'd0);

    // Flush with a busy slot
    word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(4'(i));
    push(4'h5); push(4'h6);
    pulse_flush();
    chk("fp_ready_low", {31'd0, a_nib_ready}, 32'd0);
    tick();
    chk("fp_hold_word",  a_word,             32'h12345678);
    chk("fp_hold_part",  {31'd0, a_partial}, 32'd0);
    chk("fp_hold_count", {28'd0, a_count},   32'd2);
    word_ready = 1'b1;
    tick();
    chk("fp_word",    a_word,             32'h56000000);
    chk("fp_partial", {31'd0, a_partial}, 32'd1);
    chk("fp_word_b",  b_word,             32'h00000065);
    chk("fp_ready",   {31'd0, a_nib_ready}, 32'd1);
    tick();

    // Reset mid-word with a full slot
    word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(4'(i));
    for (int i = 1; i <= 5; i++) push(4'(i));
    #3;
    RST = 1'b1;
    #1;
    chk("mr_valid", {31'd0, a_valid}, 32'd0);
    chk("mr_count", {28'd0, a_count}, 32'd0);
    #3;
    RST = 1'b0;
    word_ready = 1'b1;
    tick();
    for (int i = 8; i >= 2; i--) push(4'(i));
    chk("mr_no_word", {31'd0, a_valid}, 32'd0);
    push(4'h1);
    chk("mr_word",   a_word, 32'h87654321);
    chk("mr_word_b", b_word, 32'h12345678);
    tick();

    // Short flush, both alignments
    push(4'h1); push(4'h2);
    pulse_flush();
    chk("sf_word_b", b_word, 32'h00000021);
    chk("sf_word_a", a_word, 32'h12000000);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
